// File: rtl/warp_scheduler.sv
// Multi-warp control FSM for one compute core: keeps a PC and core state per warp and
// time-multiplexes the shared datapath, parking LSU-stalled or finished warps round-robin.
module warp_scheduler #(
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS          = 8,
  parameter bit SWITCH_EN        = 1'b1,
  localparam int WARP_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic                                   decoded_ret,
  input  logic [2:0]                             fetcher_state,
  input  logic [2*THREADS_PER_WARP*NUM_WARPS-1:0] lsu_state,
  input  logic [PC_BITS*THREADS_PER_WARP-1:0]    next_pc,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic [2:0]                             core_state,
  output logic [WARP_BITS-1:0]                   warp_select,
  output logic [NUM_WARPS-1:0]                   warp_done,
  output logic                                   done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } core_state_e;

  localparam logic [2:0] FETCHED        = 3'b010;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam int         LAST_LANE      = PC_BITS * (THREADS_PER_WARP - 1);

  core_state_e            state_q [NUM_WARPS];
  core_state_e            state_d [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_q    [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_d    [NUM_WARPS];
  logic [WARP_BITS-1:0]   warp_select_q, warp_select_d;
  logic [NUM_WARPS-1:0]   warp_done_q, warp_done_d;
  logic                   done_q, done_d;

  core_state_e            act_state;
  logic [PC_BITS-1:0]     act_pc;
  logic                   act_busy;
  logic                   nxt_found;
  logic [WARP_BITS-1:0]   nxt_sel;
  logic                   kernel_clear;

  // Only the last PC lane is consumed: there is no divergence support.
  if (THREADS_PER_WARP > 1) begin : g_unused_lanes
    logic unused_lanes;
    assign unused_lanes = ^next_pc[LAST_LANE-1:0];
  end

  // Active-warp view: its state, pc and whether any of its LSUs is still in flight.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    act_state = S_IDLE;
    act_pc    = '0;
    act_busy  = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (w == int'(warp_select_q)) begin
        act_state = state_q[w];
        act_pc    = pc_q[w];
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
          if (lsu_state[2*(w*THREADS_PER_WARP+t) +: 2] inside {LSU_REQUESTING, LSU_WAITING}) begin
            act_busy = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin scan of (w+1 .. w+N-1) mod N; descending k lets the nearest live warp win.
  always_comb begin
    nxt_found = 1'b0;
    nxt_sel   = warp_select_q;
    for (int k = NUM_WARPS - 1; k >= 1; k--) begin
      for (int j = 0; j < NUM_WARPS; j++) begin
        if (j == (int'(warp_select_q) + k) % NUM_WARPS && state_q[j] != S_DONE) begin
          nxt_found = 1'b1;
          nxt_sel   = WARP_BITS'(j);
        end
      end
    end
  end

  assign kernel_clear = done_q && !start;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    warp_select_d = warp_select_q;
    warp_done_d   = warp_done_q;

    if (kernel_clear) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_d[w] = S_IDLE;
        pc_d[w]    = '0;
      end
      warp_select_d = '0;
      warp_done_d   = '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w == int'(warp_select_q)) begin
          case (state_q[w])
            S_IDLE: begin
              if (start) begin
                for (int v = 0; v < NUM_WARPS; v++) state_d[v] = S_FETCH;
                warp_select_d = '0;
              end
            end
            S_FETCH: begin
              if (fetcher_state == FETCHED) state_d[w] = S_DECODE;
            end
            S_DECODE:  state_d[w] = S_REQUEST;
            S_REQUEST: begin
              if (decoded_ret) begin
                state_d[w]     = S_DONE;
                warp_done_d[w] = 1'b1;
              end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                state_d[w] = S_WAIT;
              end else begin
                state_d[w] = S_EXECUTE;
              end
            end
            S_WAIT: begin
              // A stalled warp stays parked in WAIT and re-checks its LSUs when reselected.
              if (!act_busy) begin
                state_d[w] = S_EXECUTE;
              end else if (SWITCH_EN && nxt_found) begin
                warp_select_d = nxt_sel;
              end
            end
            S_EXECUTE: state_d[w] = S_UPDATE;
            S_UPDATE: begin
              state_d[w] = S_FETCH;
              pc_d[w]    = next_pc[LAST_LANE +: PC_BITS];
            end
            S_DONE: begin
              if (nxt_found) warp_select_d = nxt_sel;
            end
            default: state_d[w] = S_IDLE;
          endcase
        end
      end
    end

    done_d = &warp_done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-warp arrays are small flop banks, not RAM, so they are reset explicitly.
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= S_IDLE;
        pc_q[w]    <= '0;
      end
      warp_select_q <= '0;
      warp_done_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      state_q       <= state_d;
      pc_q          <= pc_d;
      warp_select_q <= warp_select_d;
      warp_done_q   <= warp_done_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    current_pc  = act_pc;
    core_state  = act_state;
    warp_select = warp_select_q;
    warp_done   = warp_done_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: four configurations share stimulus; each is tracked by a
// behavioural model, plus a vector table and directed multi-cycle corner sequences.
module tb_warp_scheduler;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_REQUEST = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4, ST_EXECUTE = 3'd5, ST_UPDATE = 3'd6, ST_DONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start, rd, wr, ret;
  logic [2:0]  fs;
  logic [31:0] lsu_all;
  logic [31:0] next_pc;

  logic [7:0] n1_pc, n2_pc, s0_pc, n4_pc;
  logic [2:0] n1_cs, n2_cs, s0_cs, n4_cs;
  logic       n1_ws, n2_ws, s0_ws;
  logic [1:0] n4_ws;
  logic       n1_wd;
  logic [1:0] n2_wd, s0_wd;
  logic [3:0] n4_wd;
  logic       n1_dn, n2_dn, s0_dn, n4_dn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  warp_scheduler #(.NUM_WARPS(1), .THREADS_PER_WARP(4), .PC_BITS(8), .SWITCH_EN(1'b1)) u_n1 (
    .clk(clk), .reset(rst), .start(start), .decoded_mem_read_enable(rd),
    .decoded_mem_write_enable(wr), .decoded_ret(ret), .fetcher_state(fs),
    .lsu_state(lsu_all[7:0]), .next_pc(next_pc), .current_pc(n1_pc), .core_state(n1_cs),
    .warp_select(n1_ws), .warp_done(n1_wd), .done(n1_dn));

  warp_scheduler #(.NUM_WARPS(2), .THREADS_PER_WARP(4), .PC_BITS(8), .SWITCH_EN(1'b1)) u_n2 (
    .clk(clk), .reset(rst), .start(start), .decoded_mem_read_enable(rd),
    .decoded_mem_write_enable(wr), .decoded_ret(ret), .fetcher_state(fs),
    .lsu_state(lsu_all[15:0]), .next_pc(next_pc), .current_pc(n2_pc), .core_state(n2_cs),
    .warp_select(n2_ws), .warp_done(n2_wd), .done(n2_dn));

  warp_scheduler #(.NUM_WARPS(2), .THREADS_PER_WARP(4), .PC_BITS(8), .SWITCH_EN(1'b0)) u_s0 (
    .clk(clk), .reset(rst), .start(start), .decoded_mem_read_enable(rd),
    .decoded_mem_write_enable(wr), .decoded_ret(ret), .fetcher_state(fs),
    .lsu_state(lsu_all[15:0]), .next_pc(next_pc), .current_pc(s0_pc), .core_state(s0_cs),
    .warp_select(s0_ws), .warp_done(s0_wd), .done(s0_dn));

  warp_scheduler #(.NUM_WARPS(4), .THREADS_PER_WARP(4), .PC_BITS(8), .SWITCH_EN(1'b1)) u_n4 (
    .clk(clk), .reset(rst), .start(start), .decoded_mem_read_enable(rd),
    .decoded_mem_write_enable(wr), .decoded_ret(ret), .fetcher_state(fs),
    .lsu_state(lsu_all), .next_pc(next_pc), .current_pc(n4_pc), .core_state(n4_cs),
    .warp_select(n4_ws), .warp_done(n4_wd), .done(n4_dn));

  // Behavioural model: one record per configuration, stepped once per clock.
  typedef struct {
    logic [3:0][2:0] st;
    logic [3:0][7:0] pc;
    int              sel;
    logic [3:0]      wd;
    logic            dn;
  } model_t;

  model_t m  [4];
  model_t mn [4];
  int     nw_tab [4] = '{1, 2, 2, 4};
  bit     sw_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  function automatic model_t mstep(model_t s, int nw, bit sw);
    model_t     n;
    int         a;
    int         nx;
    bit         busy;
    logic [3:0] mask;
    n    = s;
    a    = s.sel;
    nx   = -1;
    busy = 1'b0;
    mask = 4'((1 << nw) - 1);
    for (int k = 1; k < nw; k++)
      if (nx < 0 && s.st[(a + k) % nw] != ST_DONE) nx = (a + k) % nw;
    for (int t = 0; t < 4; t++)
      if (lsu_all[2*(a*4+t) +: 2] inside {2'b01, 2'b10}) busy = 1'b1;
    if (rst || (s.dn && !start)) begin
      n.st  = '0;
      n.pc  = '0;
      n.sel = 0;
      n.wd  = '0;
    end else begin
      case (s.st[a])
        ST_IDLE:    if (start) begin
                      for (int w = 0; w < nw; w++) n.st[w] = ST_FETCH;
                      n.sel = 0;
                    end
        ST_FETCH:   if (fs == 3'b010) n.st[a] = ST_DECODE;
        ST_DECODE:  n.st[a] = ST_REQUEST;
        ST_REQUEST: if (ret) begin n.st[a] = ST_DONE; n.wd[a] = 1'b1; end
                    else if (rd || wr) n.st[a] = ST_WAIT;
                    else n.st[a] = ST_EXECUTE;
        ST_WAIT:    if (!busy) n.st[a] = ST_EXECUTE;
                    else if (sw && nx >= 0) n.sel = nx;
        ST_EXECUTE: n.st[a] = ST_UPDATE;
        ST_UPDATE:  begin n.st[a] = ST_FETCH; n.pc[a] = next_pc[31:24]; end
        default:    if (nx >= 0) n.sel = nx;
      endcase
    end
    n.dn = ((n.wd & mask) == mask);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input int id, input logic [31:0] cs,
                         input logic [31:0] pc, input logic [31:0] ws,
                         input logic [31:0] wd, input logic [31:0] dn);
    check({tag, " state"},     cs, 32'(m[id].st[m[id].sel]));
    check({tag, " pc"},        pc, 32'(m[id].pc[m[id].sel]));
    check({tag, " select"},    ws, 32'(m[id].sel));
    check({tag, " warp_done"}, wd, 32'(m[id].wd));
    check({tag, " done"},      dn, 32'(m[id].dn));
  endtask

  task automatic tick();
    for (int i = 0; i < 4; i++) mn[i] = mstep(m[i], nw_tab[i], sw_tab[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m[i] = mn[i];
    cmp_dut("n1", 0, 32'(n1_cs), 32'(n1_pc), 32'(n1_ws), 32'(n1_wd), 32'(n1_dn));
    cmp_dut("n2", 1, 32'(n2_cs), 32'(n2_pc), 32'(n2_ws), 32'(n2_wd), 32'(n2_dn));
    cmp_dut("s0", 2, 32'(s0_cs), 32'(s0_pc), 32'(s0_ws), 32'(s0_wd), 32'(s0_dn));
    cmp_dut("n4", 3, 32'(n4_cs), 32'(n4_pc), 32'(n4_ws), 32'(n4_wd), 32'(n4_dn));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; fs = 3'b000; rd = 1'b0; wr = 1'b0; ret = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // FETCH -> DECODE -> REQUEST -> (decision with the given decode flags).
  task automatic run_instr(input logic r, input logic w, input logic rt);
    fs = 3'b010; tick();
    fs = 3'b000; tick();
    rd = r; wr = w; ret = rt; tick();
    rd = 1'b0; wr = 1'b0; ret = 1'b0;
  endtask

  typedef struct {
    logic       rs;
    logic       st;
    logic [2:0] fs;
    logic       rt;
    logic [7:0] npc;
    logic [2:0] e_cs;
    logic [7:0] e_pc;
    logic       e_dn;
  } vec_t;

  vec_t vt [15];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m[i].st = '0; m[i].pc = '0; m[i].sel = 0; m[i].wd = '0; m[i].dn = 1'b0;
    end
    rst = 1'b1; start = 1'b0; fs = 3'b000; rd = 1'b0; wr = 1'b0; ret = 1'b0;
    lsu_all = 32'hFFFF_FFFF; next_pc = 32'h0;

    // Single warp: ADD then RET, fetch takes 2 cycles each time.
    vt[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 8'h00, ST_IDLE,    8'h00, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_FETCH,   8'h00, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_FETCH,   8'h00, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 3'b010, 1'b0, 8'h00, ST_DECODE,  8'h00, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_REQUEST, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_EXECUTE, 8'h00, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h01, ST_UPDATE,  8'h00, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h01, ST_FETCH,   8'h01, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_FETCH,   8'h01, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 3'b010, 1'b0, 8'h00, ST_DECODE,  8'h01, 1'b0};
    vt[10] = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_REQUEST, 8'h01, 1'b0};
    vt[11] = '{1'b0, 1'b1, 3'b000, 1'b1, 8'h00, ST_DONE,    8'h01, 1'b1};
    vt[12] = '{1'b0, 1'b1, 3'b000, 1'b0, 8'h00, ST_DONE,    8'h01, 1'b1};
    vt[13] = '{1'b0, 1'b0, 3'b000, 1'b0, 8'h00, ST_IDLE,    8'h00, 1'b0};
    vt[14] = '{1'b0, 1'b0, 3'b000, 1'b0, 8'h00, ST_IDLE,    8'h00, 1'b0};

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rs; start = vt[i].st; fs = vt[i].fs; ret = vt[i].rt;
      rd = 1'b0; wr = 1'b0; next_pc = {vt[i].npc, 24'h0};
      tick();
      check($sformatf("t2[%0d] state", i), 32'(n1_cs), 32'(vt[i].e_cs));
      check($sformatf("t2[%0d] pc", i),    32'(n1_pc), 32'(vt[i].e_pc));
      check($sformatf("t2[%0d] done", i),  32'(n1_dn), 32'(vt[i].e_dn));
      check($sformatf("t2[%0d] wdone", i), 32'(n1_wd), 32'(vt[i].e_dn));
    end

    // Reset mid-kernel while warp 1 executes at pc 0x12.
    do_reset();
    lsu_all = 32'hFFFF_FF55; next_pc = 32'h0; start = 1'b1;
    tick();
    run_instr(1'b1, 1'b0, 1'b0);
    tick();
    check("t1 switched", 32'(n2_ws), 32'd1);
    next_pc = 32'h1200_0000;
    run_instr(1'b0, 1'b0, 1'b0);
    tick(); tick();
    run_instr(1'b0, 1'b0, 1'b0);
    check("t1 pre state", 32'(n2_cs), 32'(ST_EXECUTE));
    check("t1 pre pc", 32'(n2_pc), 32'h12);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t1 state", 32'(n2_cs), 32'(ST_IDLE));
    check("t1 pc", 32'(n2_pc), 32'h0);
    check("t1 select", 32'(n2_ws), 32'd0);
    check("t1 wdone", 32'(n2_wd), 32'd0);
    check("t1 done", 32'(n2_dn), 32'd0);

    // Store with idle LSUs, then a non-memory op.
    do_reset();
    lsu_all = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    run_instr(1'b0, 1'b1, 1'b0);
    check("t6 wait", 32'(n2_cs), 32'(ST_WAIT));
    tick();
    check("t6 exec", 32'(n2_cs), 32'(ST_EXECUTE));
    check("t6 no switch", 32'(n2_ws), 32'd0);
    tick(); tick();
    check("t6 fetch", 32'(n2_cs), 32'(ST_FETCH));
    run_instr(1'b0, 1'b0, 1'b0);
    check("t6 req->exec", 32'(n2_cs), 32'(ST_EXECUTE));

    // Warp 0 load stalls: switching vs. non-switching configuration.
    do_reset();
    lsu_all = 32'hFFFF_FF55; next_pc = 32'h2000_0000; start = 1'b1;
    tick();
    run_instr(1'b1, 1'b0, 1'b0);
    check("t3 wait", 32'(n2_cs), 32'(ST_WAIT));
    check("t4 wait", 32'(s0_cs), 32'(ST_WAIT));
    tick();
    check("t3 select", 32'(n2_ws), 32'd1);
    check("t3 w1 fetch", 32'(n2_cs), 32'(ST_FETCH));
    check("t4 select", 32'(s0_ws), 32'd0);
    run_instr(1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("t3 w1 pc", 32'(n2_pc), 32'h20);
    check("t4 still wait", 32'(s0_cs), 32'(ST_WAIT));
    run_instr(1'b0, 1'b0, 1'b1);
    check("t3 w1 ret", 32'(n2_wd), 32'h2);
    tick();
    check("t3 reselect", 32'(n2_ws), 32'd0);
    check("t3 resel wait", 32'(n2_cs), 32'(ST_WAIT));
    lsu_all = 32'hFFFF_FFFF;
    tick();
    check("t3 resume", 32'(n2_cs), 32'(ST_EXECUTE));
    check("t4 resume", 32'(s0_cs), 32'(ST_EXECUTE));
    check("t4 select 0", 32'(s0_ws), 32'd0);
    tick(); tick();
    run_instr(1'b0, 1'b0, 1'b1);
    check("t3 done", 32'(n2_dn), 32'd1);
    check("t4 w0 done", 32'(s0_wd), 32'h1);
    check("t4 still 0", 32'(s0_ws), 32'd0);
    tick();
    check("t4 to w1", 32'(s0_ws), 32'd1);
    check("t4 w1 fetch", 32'(s0_cs), 32'(ST_FETCH));

    // Four warps: 1 and 2 finish, 3 stalls -> wraps to 0, then 0 skips 1,2 back to 3.
    do_reset();
    lsu_all = 32'h55FF_FF55; start = 1'b1;
    tick();
    run_instr(1'b1, 1'b0, 1'b0);
    tick();
    check("t5 to w1", 32'(n4_ws), 32'd1);
    run_instr(1'b0, 1'b0, 1'b1);
    tick();
    check("t5 to w2", 32'(n4_ws), 32'd2);
    run_instr(1'b0, 1'b0, 1'b1);
    tick();
    check("t5 to w3", 32'(n4_ws), 32'd3);
    check("t5 wdone", 32'(n4_wd), 32'h6);
    run_instr(1'b1, 1'b0, 1'b0);
    check("t5 w3 wait", 32'(n4_cs), 32'(ST_WAIT));
    tick();
    check("t5 wrap", 32'(n4_ws), 32'd0);
    tick();
    check("t5 skip", 32'(n4_ws), 32'd3);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 9) != 0);
      fs      = $urandom_range(0, 1) ? 3'b010 : 3'($urandom_range(0, 7));
      rd      = ($urandom_range(0, 3) == 0);
      wr      = ($urandom_range(0, 3) == 0);
      ret     = ($urandom_range(0, 9) == 0);
      next_pc = $urandom;
      for (int f = 0; f < 16; f++) lsu_all[2*f +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
